eth_rx_fcs_check: RTL and testbench
===================================

Name: eth_rx_fcs_check

Overview:
- Receive-side counterpart of the team's byte-wide CRC32 FCS generator.
- Consumes a MAC receive byte stream in which each frame ends with a 4-byte Ethernet FCS.
- Recomputes CRC32 over the whole frame (reflected input, init 0xFFFFFFFF) and checks the residue.
- Strips the FCS before forwarding payload, and emits one status pulse per frame carrying CRC, length and PHY-error flags.
- Sits between the RMII/MII byte assembler and the RX buffer.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes including FCS.
- MAX_LEN, 1518, maximum legal frame length in bytes including FCS.
- LEN_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  receive byte, LSB is first bit on the wire.
- in_valid  in  1  in_data valid this cycle; no backpressure exists.
- in_last  in  1  marks the final FCS byte of the frame; qualified by in_valid.
- in_err  in  1  PHY receive error for this byte; qualified by in_valid.
- out_data  out  8  payload byte with FCS stripped.
- out_valid  out  1  out_data valid.
- out_last  out  1  last payload byte of the frame.
- stat_valid  out  1  one-cycle pulse; stat_* fields valid.
- stat_crc_ok  out  1  residue matched.
- stat_runt  out  1  stat_len < MIN_LEN.
- stat_oversize  out  1  stat_len > MAX_LEN.
- stat_phy_err  out  1  in_err seen anywhere in the frame.
- stat_len  out  LEN_W  frame bytes including FCS, saturating at 2^LEN_W-1.

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, CRC register 0xFFFFFFFF, delay line empty, counter 0, FSM to IDLE. A partial frame in flight is discarded and produces no status.
- All outputs are registered. Latency from input byte k to its output is the cycle after byte k+4 is accepted.
- FSM states and transitions:
  - IDLE: first in_valid starts a frame; go to FILL.
  - FILL: fewer than 4 bytes held; after the 4th byte go to STREAM.
  - STREAM: each accepted byte shifts the 4-deep delay line and the oldest byte is emitted as out_data/out_valid.
  - in_last: from any state, in_last returns the FSM to IDLE on the same edge.
- Gaps: in_valid=0 mid-frame holds all state. No timeout.
- CRC: on every accepted byte (FCS bytes included), crc <= crc32_byte(crc, bitrev8(in_data)) in non-reflected register form.
  - Frame good iff the post-update register equals 0xC704DD7B (result form ~bitrev32 = 0x2144DF1C).
  - CRC register reloads 0xFFFFFFFF on the edge that accepts in_last, so a back-to-back frame may start on the next cycle.
- End of frame (in_valid & in_last accepted):
  - Next cycle: stat_valid=1 with all fields.
  - If the frame has ≥5 bytes, the byte emitted in that same cycle carries out_last=1.
  - The 4 remaining delay-line bytes (the FCS) are dropped.
- Frames of 1–4 bytes: no out_valid at all, stat_valid pulses, stat_runt=1, stat_crc_ok from residue.
- A 1-byte frame (in_last on the first byte) is legal.
- Counter: increments per accepted byte and saturates. Oversize and runt frames are still forwarded; they are only flagged.
- stat_phy_err is sticky within the frame and cleared at the next frame start.

Decomposition:
- Shared package/header (eth_pkg):
  - CRC32_INIT = 0xFFFFFFFF and CRC32_RESIDUE = 0xC704DD7B.
  - crc32_byte next-state function for polynomial 0x04C11DB7.
  - bitrev8 and bitrev32 functions.
  - FSM state encodings IDLE/FILL/STREAM.
- One sub-module, eth_fcs_delay4: 4-byte shift register with occupancy count, shift enable and flush.

Test Plan:
- Frame 31 32 33 34 35 36 37 38 39 26 39 F4 CB, in_last on CB:
  - out_data 31..39 with out_last on 39.
  - stat_crc_ok=1, stat_len=13, stat_runt=1.
- Same frame with byte 35 changed to 34 → stat_crc_ok=0; the payload is still forwarded unchanged.
- 64-byte frame of 60×0x00 plus correct FCS, back-to-back with a second identical frame (no idle cycle):
  - Two stat_valid pulses, both crc_ok=1, len=64, runt=0.
  - 60 payload bytes out each.
- 3-byte frame AA BB CC → no out_valid; stat_valid=1, len=3, runt=1.
- 1519-byte frame → stat_oversize=1, with 1515 payload bytes out. in_err pulsed on byte 10 → stat_phy_err=1 for this frame and 0 for the following frame.
- rst asserted after byte 7 of a frame → outputs 0 next cycle, no stat_valid. A following clean frame checks crc_ok=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared CRC32 helpers and FSM encodings for the Ethernet receive path.
// The CRC register is kept in non-reflected form; bytes are bit-reversed on entry.
package eth_pkg;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  // MSB-first update; d[7] is the first bit on the wire once bitrev8 is applied.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_delay4.sv
// Four-byte delay line that holds back the trailing FCS until the frame ends.
module eth_fcs_delay4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_i,
  input  logic       flush_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic [2:0] count_o
);

  logic [3:0][7:0] mem_q;
  logic [2:0]      count_q;

  // Shift new bytes in at index 0; flush only empties the occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= 32'h0000_0000;
      count_q <= 3'd0;
    end else if (flush_i) begin
      count_q <= 3'd0;
    end else if (shift_i) begin
      mem_q <= {mem_q[2:0], data_i};
      if (count_q != 3'd4) count_q <= count_q + 3'd1;
    end
  end

  assign data_o  = mem_q[3];
  assign count_o = count_q;

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: recomputes CRC32 over each frame, strips the 4 FCS bytes
// and reports CRC, length and PHY-error status once per frame.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_err,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             stat_valid,
  output logic             stat_crc_ok,
  output logic             stat_runt,
  output logic             stat_oversize,
  output logic             stat_phy_err,
  output logic [LEN_W-1:0] stat_len
);

  localparam logic [LEN_W-1:0] MIN_C = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] SAT_C = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] ONE_C = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ZERO_C = {LEN_W{1'b0}};

  logic [1:0]       state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             phy_err_q, phy_err_d;

  logic [31:0]      crc_upd_s;
  logic [LEN_W-1:0] len_inc_s;
  logic             err_acc_s, emit_s, eof_s;
  logic [7:0]       dly_data_s;
  logic [2:0]       dly_count_s;

  logic [7:0]       out_data_q;
  logic             out_valid_q, out_last_q;
  logic             stat_valid_q, stat_crc_ok_q, stat_runt_q, stat_oversize_q, stat_phy_err_q;
  logic [LEN_W-1:0] stat_len_q;

  eth_fcs_delay4 u_delay (
    .clk     (clk),
    .rst     (rst),
    .shift_i (in_valid & ~in_last),
    .flush_i (eof_s),
    .data_i  (in_data),
    .data_o  (dly_data_s),
    .count_o (dly_count_s)
  );

  // Per-byte datapath terms shared by next-state and status logic.
  always_comb begin
    crc_upd_s = crc32_byte(crc_q, bitrev8(in_data));
    len_inc_s = (len_q == SAT_C) ? len_q : len_q + ONE_C;
    err_acc_s = ((state_q == ST_IDLE) ? 1'b0 : phy_err_q) | in_err;
    emit_s    = in_valid & (state_q == ST_STREAM);
    eof_s     = in_valid & in_last;
  end

  // Frame FSM, CRC register, byte counter and sticky PHY error.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    phy_err_d = phy_err_q;
    if (eof_s) begin
      state_d   = ST_IDLE;
      crc_d     = CRC32_INIT;
      len_d     = ZERO_C;
      phy_err_d = 1'b0;
    end else if (in_valid) begin
      crc_d     = crc_upd_s;
      len_d     = len_inc_s;
      phy_err_d = err_acc_s;
      case (state_q)
        ST_IDLE:   state_d = ST_FILL;
        ST_FILL:   state_d = (dly_count_s == 3'd3) ? ST_STREAM : ST_FILL;
        ST_STREAM: state_d = ST_STREAM;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC32_INIT;
      len_q     <= ZERO_C;
      phy_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      phy_err_q <= phy_err_d;
    end
  end

  // Registered payload and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q      <= 8'h00;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      stat_valid_q    <= 1'b0;
      stat_crc_ok_q   <= 1'b0;
      stat_runt_q     <= 1'b0;
      stat_oversize_q <= 1'b0;
      stat_phy_err_q  <= 1'b0;
      stat_len_q      <= ZERO_C;
    end else begin
      out_valid_q     <= emit_s;
      out_last_q      <= emit_s & in_last;
      out_data_q      <= emit_s ? dly_data_s : out_data_q;
      stat_valid_q    <= eof_s;
      stat_crc_ok_q   <= eof_s & (crc_upd_s == CRC32_RESIDUE);
      stat_runt_q     <= eof_s & (len_inc_s < MIN_C);
      stat_oversize_q <= eof_s & (len_inc_s > MAX_C);
      stat_phy_err_q  <= eof_s & err_acc_s;
      stat_len_q      <= eof_s ? len_inc_s : ZERO_C;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign stat_valid    = stat_valid_q;
  assign stat_crc_ok   = stat_crc_ok_q;
  assign stat_runt     = stat_runt_q;
  assign stat_oversize = stat_oversize_q;
  assign stat_phy_err  = stat_phy_err_q;
  assign stat_len      = stat_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check with a frame-level reference model
// (reflected CRC32, payload/status queues) and a per-cycle output comparator.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_last = 1'b0, in_err = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic        stat_valid, stat_crc_ok, stat_runt, stat_oversize, stat_phy_err;
  logic [15:0] stat_len;

  eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_err(in_err), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .stat_valid(stat_valid), .stat_crc_ok(stat_crc_ok), .stat_runt(stat_runt),
    .stat_oversize(stat_oversize), .stat_phy_err(stat_phy_err), .stat_len(stat_len)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic [7:0]  frm[$];
  logic [8:0]  exp_q[$];
  logic [19:0] stat_q[$];
  logic [7:0]  rx_q[$];
  int          stat_cnt = 0, rx_last_cnt = 0;
  logic [19:0] last_stat = 20'h0;
  logic [8:0]  e_byte;
  logic [19:0] e_stat;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reflected CRC32 over frm[0..n-1], no final inversion.
  function automatic logic [31:0] crc_raw(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = ~crc_raw(frm.size());
    frm.push_back(f[7:0]);  frm.push_back(f[15:8]);
    frm.push_back(f[23:16]); frm.push_back(f[31:24]);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic l, input logic e);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = b; in_last = l; in_err = e;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    end
  endtask

  task automatic send_frame(input int err_at, input int gap_at);
    int n;
    logic [19:0] s;
    n = frm.size();
    for (int i = 0; i < n - 4; i++) exp_q.push_back({(i == n - 5), frm[i]});
    s[19] = (crc_raw(n) == 32'hDEBB_20E3);
    s[18] = (n < 64);
    s[17] = (n > 1518);
    s[16] = (err_at >= 0 && err_at < n);
    s[15:0] = (n > 65535) ? 16'hFFFF : 16'(n);
    stat_q.push_back(s);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) idle(2);
      drive_byte(frm[i], (i == n - 1), (i == err_at));
    end
  endtask

  task automatic send_partial(input int k);
    for (int i = 0; i < k - 4; i++) exp_q.push_back({1'b0, frm[i]});
    for (int i = 0; i < k; i++) drive_byte(frm[i], 1'b0, 1'b0);
  endtask

  task automatic build_f1();
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    append_fcs();
  endtask

  // Compare every output beat and status pulse against the model queues.
  always @(negedge clk) begin
    if (chk_en && out_valid) begin
      rx_q.push_back(out_data);
      if (out_last) rx_last_cnt++;
      if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        e_byte = exp_q.pop_front();
        chk("out_data", {24'h0, out_data}, {24'h0, e_byte[7:0]});
        chk("out_last", {31'h0, out_last}, {31'h0, e_byte[8]});
      end
    end
    if (chk_en && stat_valid) begin
      stat_cnt++;
      last_stat = {stat_crc_ok, stat_runt, stat_oversize, stat_phy_err, stat_len};
      if (stat_q.size() == 0) chk("unexpected_stat", 32'd1, 32'd0);
      else begin
        e_stat = stat_q.pop_front();
        chk("stat_crc_ok", {31'h0, stat_crc_ok}, {31'h0, e_stat[19]});
        chk("stat_runt", {31'h0, stat_runt}, {31'h0, e_stat[18]});
        chk("stat_oversize", {31'h0, stat_oversize}, {31'h0, e_stat[17]});
        chk("stat_phy_err", {31'h0, stat_phy_err}, {31'h0, e_stat[16]});
        chk("stat_len", {16'h0, stat_len}, {16'h0, e_stat[15:0]});
      end
    end
  end

  initial begin
    int sc0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {1'b0, out_data, out_valid, out_last, stat_valid, stat_crc_ok,
        stat_runt, stat_oversize, stat_phy_err, stat_len}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reference vector "123456789" pins the model's CRC and FCS byte order.
    build_f1();
    chk("model_crc_123456789", crc_raw(9) ^ 32'hFFFF_FFFF, 32'hCBF4_3926);
    chk("model_fcs_bytes", {frm[9], frm[10], frm[11], frm[12]}, 32'h2639_F4CB);
    rx_q.delete();
    send_frame(-1, 5);
    idle(4);
    chk("f1_payload_count", rx_q.size(), 32'd9);
    chk("f1_last_payload", {24'h0, rx_q[8]}, 32'h39);
    chk("f1_stat", {12'h0, last_stat}, {12'h0, 4'b1100, 16'd13});

    build_f1();
    frm[4] = 8'h34;
    rx_q.delete();
    send_frame(-1, -1);
    idle(4);
    chk("f1bad_crc_ok", {31'h0, last_stat[19]}, 32'd0);
    chk("f1bad_payload_byte4", {24'h0, rx_q[4]}, 32'h34);

    frm.delete();
    for (int i = 0; i < 60; i++) frm.push_back(8'h00);
    append_fcs();
    rx_q.delete();
    sc0 = stat_cnt;
    send_frame(-1, -1);
    send_frame(-1, -1);
    idle(4);
    chk("b2b_stat_pulses", stat_cnt - sc0, 32'd2);
    chk("b2b_payload_count", rx_q.size(), 32'd120);
    chk("b2b_stat", {12'h0, last_stat}, {12'h0, 4'b1000, 16'd64});

    frm.delete();
    for (int i = 0; i < 1515; i++) frm.push_back(8'(i));
    append_fcs();
    rx_q.delete();
    send_frame(9, -1);
    idle(4);
    chk("over_payload_count", rx_q.size(), 32'd1515);
    chk("over_stat", {12'h0, last_stat}, {12'h0, 4'b1011, 16'd1519});

    frm.delete();
    frm.push_back(8'hAA); frm.push_back(8'hBB); frm.push_back(8'hCC);
    rx_q.delete();
    send_frame(-1, -1);
    idle(4);
    chk("short_payload_count", rx_q.size(), 32'd0);
    chk("short_stat_fields", {13'h0, last_stat[18:0]}, {13'h0, 3'b100, 16'd3});

    // Reset mid-frame: no status, outputs cleared, then a clean frame.
    frm.delete();
    for (int i = 0; i < 20; i++) frm.push_back(8'h50 + 8'(i));
    sc0 = stat_cnt;
    send_partial(7);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outputs", {1'b0, out_data, out_valid, out_last, stat_valid, stat_crc_ok,
        stat_runt, stat_oversize, stat_phy_err, stat_len}, 32'd0);
    rst = 1'b0;
    idle(2);
    chk("midrst_no_stat", stat_cnt - sc0, 32'd0);
    build_f1();
    rx_q.delete();
    send_frame(-1, -1);
    idle(6);
    chk("post_rst_stat", {12'h0, last_stat}, {12'h0, 4'b1100, 16'd13});
    chk("post_rst_payload_count", rx_q.size(), 32'd9);

    chk("exp_payload_drained", exp_q.size(), 32'd0);
    chk("exp_stat_drained", stat_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
